// File: rtl/regfile_spill_engine.sv
// Spill/fill sequencer: moves r1..rNUM_GPR (and optionally cr1..cr7) between the
// register file and data RAM port 2, one word per cycle.
module regfile_spill_engine #(
  parameter int NUM_GPR = 7,
  parameter int SAVE_CR = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        dir,
  input  logic [15:0] base,
  output logic        busy,
  output logic        done,
  output logic [3:0]  rf_rabus,
  input  logic [15:0] rf_rdbus,
  output logic [3:0]  rf_wabus,
  output logic [15:0] rf_wdbus,
  output logic [15:0] mem_abus,
  output logic [15:0] mem_dbus_o,
  output logic        mem_we,
  input  logic [15:0] mem_dbus_i
);

  localparam int         N    = NUM_GPR + 7 * SAVE_CR;
  localparam logic [3:0] LAST = 4'(N - 1);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t      state;
  logic [3:0]  idx;
  logic        dir_q;
  logic [15:0] base_q;

  // General registers first, then the control bank; r0/cr0 are skipped.
  function automatic logic [3:0] reg_of(input logic [3:0] i);
    logic [3:0] r;
    if (i < 4'(NUM_GPR)) r = {1'b0, 3'(i + 4'd1)};
    else                 r = {1'b1, 3'(i - 4'(NUM_GPR) + 4'd1)};
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      dir_q  <= 1'b0;
      base_q <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            dir_q  <= dir;
            base_q <= base;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= XFER;
          end
        end
        XFER: begin
          idx <= idx + 4'd1;
          if (idx == LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Write strobes are masked by reset so an aborted transfer never writes.
  always_comb begin
    rf_rabus   = 4'h0;
    rf_wabus   = 4'h0;
    rf_wdbus   = 16'h0;
    mem_abus   = 16'h0;
    mem_dbus_o = 16'h0;
    mem_we     = 1'b0;
    if (state == XFER) begin
      mem_abus = base_q + {12'd0, idx};
      if (!dir_q) begin
        rf_rabus   = reg_of(idx);
        mem_dbus_o = rf_rdbus;
        mem_we     = ~reset;
      end else begin
        rf_wabus = reset ? 4'h0 : reg_of(idx);
        rf_wdbus = mem_dbus_i;
      end
    end
  end

endmodule

// File: tb/tb_regfile_spill_engine.sv
// Directed bench for regfile_spill_engine: behavioural regfile and RAM models,
// a per-cycle vector table for a save, and hand-written multi-cycle sequences.
module tb_regfile_spill_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, dir, start2;
  logic [15:0] base;
  logic        busy, done, mem_we;
  logic [3:0]  rf_rabus, rf_wabus;
  logic [15:0] rf_rdbus, rf_wdbus, mem_abus, mem_dbus_o, mem_dbus_i;
  logic        busy2, done2, mem_we2;
  logic [3:0]  rf_rabus2, rf_wabus2;
  logic [15:0] rf_rdbus2, rf_wdbus2, mem_abus2, mem_dbus_o2, mem_dbus_i2;

  logic [15:0] rf   [16];
  logic [15:0] mem  [65536];
  logic [15:0] mem2 [65536];

  logic        pre_rwe, pre_mwe;
  logic [3:0]  pre_raddr;
  logic [15:0] pre_rdata, pre_maddr, pre_mdata;

  regfile_spill_engine dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .base(base),
    .busy(busy), .done(done), .rf_rabus(rf_rabus), .rf_rdbus(rf_rdbus),
    .rf_wabus(rf_wabus), .rf_wdbus(rf_wdbus), .mem_abus(mem_abus),
    .mem_dbus_o(mem_dbus_o), .mem_we(mem_we), .mem_dbus_i(mem_dbus_i)
  );

  regfile_spill_engine #(.NUM_GPR(7), .SAVE_CR(0)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .dir(dir), .base(base),
    .busy(busy2), .done(done2), .rf_rabus(rf_rabus2), .rf_rdbus(rf_rdbus2),
    .rf_wabus(rf_wabus2), .rf_wdbus(rf_wdbus2), .mem_abus(mem_abus2),
    .mem_dbus_o(mem_dbus_o2), .mem_we(mem_we2), .mem_dbus_i(mem_dbus_i2)
  );

  assign rf_rdbus    = rf[rf_rabus];
  assign rf_rdbus2   = rf[rf_rabus2];
  assign mem_dbus_i  = mem[mem_abus];
  assign mem_dbus_i2 = mem2[mem_abus2];

  // Regfile writes whenever regnum != 0, like the real write port.
  always @(posedge clk) begin
    if (pre_rwe) rf[pre_raddr] <= pre_rdata;
    else if (rf_wabus[2:0] != 3'd0) rf[rf_wabus] <= rf_wdbus;
    if (pre_mwe) mem[pre_maddr] <= pre_mdata;
    else if (mem_we) mem[mem_abus] <= mem_dbus_o;
    if (mem_we2) mem2[mem_abus2] <= mem_dbus_o2;
  end

  typedef struct {
    logic        busy;
    logic        done;
    logic        we;
    logic [3:0]  ra;
    logic [15:0] ma;
    logic [15:0] md;
  } vec_t;

  vec_t tbl [16];
  int checks = 0;
  int errors = 0;
  int o_busy, o_done, o_we, o_rfw, o_out, o_acc03;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_rf(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_rwe = 1'b1; pre_raddr = a; pre_rdata = d;
  endtask

  task automatic set_mem(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_mwe = 1'b1; pre_maddr = a; pre_mdata = d;
  endtask

  task automatic pre_off();
    @(negedge clk);
    pre_rwe = 1'b0; pre_mwe = 1'b0;
  endtask

  // Leaves the bench at the negedge of XFER cycle 1; dir/base are then scrambled.
  task automatic do_start(input logic d, input logic [15:0] b);
    @(negedge clk);
    start = 1'b1; dir = d; base = b;
    @(negedge clk);
    start = 1'b0; dir = ~d; base = ~b;
  endtask

  task automatic watch(input int reset_at, input logic pulse);
    o_busy = 0; o_done = -1; o_we = 0; o_rfw = 0; o_out = 0; o_acc03 = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clk);
      if (reset_at > 0 && c == reset_at) reset = 1'b1;
      if (reset_at > 0 && c == reset_at + 1) reset = 1'b0;
      if (pulse && c == 5) begin start = 1'b1; dir = 1'b1; base = 16'h0300; end
      if (pulse && c == 6) start = 1'b0;
      #1;
      if (busy) o_busy++;
      if (mem_we) o_we++;
      if (rf_wabus[2:0] != 3'd0) o_rfw++;
      if (mem_we && mem_abus > 16'h0007 && mem_abus < 16'hFFFA) o_out++;
      if (mem_abus[15:8] == 8'h03) o_acc03++;
      if (reset_at > 0 && c == reset_at) begin
        chk("reset_cycle_rf_wabus", 32'(rf_wabus), 32'h0);
        chk("reset_cycle_mem_we", 32'(mem_we), 32'h0);
      end
      if (reset_at > 0 && c == reset_at + 1) begin
        chk("after_reset_busy", 32'(busy), 32'h0);
        chk("after_reset_done", 32'(done), 32'h0);
        break;
      end
      if (done) begin o_done = c; break; end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] a;
    int d2_busy, d2_we, d2_cr, d2_rfw, d2_done;
    reset = 1'b1; start = 1'b0; start2 = 1'b0; dir = 1'b0; base = 16'h0;
    pre_rwe = 1'b0; pre_mwe = 1'b0; pre_raddr = 4'h0; pre_rdata = 16'h0;
    pre_maddr = 16'h0; pre_mdata = 16'h0;

    tbl[0]  = '{1'b1, 1'b0, 1'b1, 4'h1, 16'h0100, 16'h1111};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 4'h2, 16'h0101, 16'h2222};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 4'h3, 16'h0102, 16'h3333};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 4'h4, 16'h0103, 16'h4444};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 4'h5, 16'h0104, 16'h5555};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 4'h6, 16'h0105, 16'h6666};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 4'h7, 16'h0106, 16'h7777};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 4'h9, 16'h0107, 16'hC001};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 4'hA, 16'h0108, 16'hC002};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 4'hB, 16'h0109, 16'hC003};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 4'hC, 16'h010A, 16'hC004};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 4'hD, 16'h010B, 16'hC005};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 4'hE, 16'h010C, 16'hC006};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 4'hF, 16'h010D, 16'hC007};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 4'h0, 16'h0000, 16'h0000};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000};

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_mem_we", 32'(mem_we), 32'h0);
    chk("reset_rf_wabus", 32'(rf_wabus), 32'h0);
    chk("reset_mem_abus", 32'(mem_abus), 32'h0);
    chk("reset_busy2", 32'(busy2), 32'h0);
    reset = 1'b0;

    for (int k = 1; k <= 7; k++) set_rf(4'(k), 16'(k * 16'h1111));
    for (int k = 1; k <= 7; k++) set_rf(4'(8 + k), 16'hC000 + 16'(k));
    pre_off();

    // Save with defaults, checked cycle by cycle
    do_start(1'b0, 16'h0100);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk($sformatf("save_busy_c%0d", i + 1), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("save_done_c%0d", i + 1), 32'(done), 32'(tbl[i].done));
      chk($sformatf("save_we_c%0d", i + 1), 32'(mem_we), 32'(tbl[i].we));
      chk($sformatf("save_rabus_c%0d", i + 1), 32'(rf_rabus), 32'(tbl[i].ra));
      chk($sformatf("save_abus_c%0d", i + 1), 32'(mem_abus), 32'(tbl[i].ma));
      chk($sformatf("save_dout_c%0d", i + 1), 32'(mem_dbus_o), 32'(tbl[i].md));
      chk($sformatf("save_wabus_c%0d", i + 1), 32'(rf_wabus), 32'h0);
    end
    for (int i = 0; i < 14; i++)
      chk($sformatf("save_mem_%0h", tbl[i].ma), 32'(mem[tbl[i].ma]), 32'(tbl[i].md));
    for (int k = 1; k <= 7; k++) begin
      chk($sformatf("save_rf_r%0d", k), 32'(rf[k]), 32'(16'(k * 16'h1111)));
      chk($sformatf("save_rf_cr%0d", k), 32'(rf[8 + k]), 32'(16'hC000 + 16'(k)));
    end

    // Restore
    for (int k = 0; k < 14; k++) set_mem(16'h0200 + 16'(k), 16'hA000 + 16'(k));
    pre_off();
    do_start(1'b1, 16'h0200);
    watch(0, 1'b0);
    chk("restore_busy_cycles", 32'(o_busy), 32'd14);
    chk("restore_done_cycle", 32'(o_done), 32'd15);
    chk("restore_mem_we_cycles", 32'(o_we), 32'd0);
    chk("restore_rf_writes", 32'(o_rfw), 32'd14);
    for (int k = 1; k <= 7; k++) begin
      chk($sformatf("restore_r%0d", k), 32'(rf[k]), 32'(16'hA000 + 16'(k - 1)));
      chk($sformatf("restore_cr%0d", k), 32'(rf[8 + k]), 32'(16'hA006 + 16'(k)));
    end

    // Save across the top of the address space
    do_start(1'b0, 16'hFFFA);
    watch(0, 1'b0);
    chk("wrap_done_cycle", 32'(o_done), 32'd15);
    chk("wrap_we_cycles", 32'(o_we), 32'd14);
    chk("wrap_out_of_range", 32'(o_out), 32'd0);
    for (int k = 0; k < 14; k++) begin
      a = 16'hFFFA + 16'(k);
      chk($sformatf("wrap_mem_%0h", a), 32'(mem[a]), 32'(16'hA000 + 16'(k)));
    end

    // start pulsed mid-save must be ignored and not queued
    do_start(1'b0, 16'h0100);
    watch(0, 1'b1);
    chk("busy_start_busy_cycles", 32'(o_busy), 32'd14);
    chk("busy_start_done_cycle", 32'(o_done), 32'd15);
    chk("busy_start_we_cycles", 32'(o_we), 32'd14);
    chk("busy_start_03xx_access", 32'(o_acc03), 32'd0);
    @(negedge clk); #1;
    chk("busy_start_not_queued", 32'(busy), 32'h0);
    for (int k = 0; k < 14; k++)
      chk($sformatf("busy_start_mem_%0h", 16'h0100 + 16'(k)),
          32'(mem[16'h0100 + 16'(k)]), 32'(16'hA000 + 16'(k)));

    // Reset in XFER cycle 6 of a restore
    for (int k = 0; k < 14; k++) set_mem(16'h0500 + 16'(k), 16'hB000 + 16'(k));
    pre_off();
    do_start(1'b1, 16'h0500);
    watch(6, 1'b0);
    chk("reset_mid_rf_writes", 32'(o_rfw), 32'd5);
    @(negedge clk); #1;
    for (int k = 1; k <= 5; k++)
      chk($sformatf("reset_mid_r%0d", k), 32'(rf[k]), 32'(16'hB000 + 16'(k - 1)));
    chk("reset_mid_r6", 32'(rf[6]), 32'h0000A005);
    chk("reset_mid_r7", 32'(rf[7]), 32'h0000A006);
    chk("reset_mid_cr1", 32'(rf[9]), 32'h0000A007);
    chk("reset_mid_busy_idle", 32'(busy), 32'h0);

    // General registers only (SAVE_CR = 0)
    @(negedge clk);
    start2 = 1'b1; dir = 1'b0; base = 16'h0040;
    @(negedge clk);
    start2 = 1'b0; dir = 1'b1; base = 16'h0;
    d2_busy = 0; d2_we = 0; d2_cr = 0; d2_rfw = 0; d2_done = -1;
    for (int c = 1; c <= 30; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      if (busy2) d2_busy++;
      if (mem_we2) d2_we++;
      if (rf_rabus2[3]) d2_cr++;
      if (rf_wabus2 != 4'h0 || rf_wdbus2 != 16'h0) d2_rfw++;
      if (done2) begin d2_done = c; break; end
    end
    chk("gpr_only_done_cycle", 32'(d2_done), 32'd8);
    chk("gpr_only_busy_cycles", 32'(d2_busy), 32'd7);
    chk("gpr_only_we_cycles", 32'(d2_we), 32'd7);
    chk("gpr_only_cr_addressed", 32'(d2_cr), 32'd0);
    chk("gpr_only_rf_write", 32'(d2_rfw), 32'd0);
    for (int k = 0; k < 5; k++)
      chk($sformatf("gpr_only_mem_%0h", 16'h0040 + 16'(k)),
          32'(mem2[16'h0040 + 16'(k)]), 32'(16'hB000 + 16'(k)));
    chk("gpr_only_mem_45", 32'(mem2[16'h0045]), 32'h0000A005);
    chk("gpr_only_mem_46", 32'(mem2[16'h0046]), 32'h0000A006);
    chk("gpr_only_mem_47", 32'(mem2[16'h0047]), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
